// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared constants, types and FSM encoding for the argmax stage
package dnn_pkg;

    localparam int DNN_DATA_WIDTH  = 7;
    localparam int DNN_NUM_CLASSES = 10;
    localparam int DNN_IDX_WIDTH   = 4;

    typedef logic signed [DNN_DATA_WIDTH-1:0] act_t;
    typedef logic [DNN_IDX_WIDTH-1:0]         cls_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2,
        HOLD = 2'd3
    } argmax_state_t;

endpackage

// File: rtl/dnn_top2_tracker.sv
// rtl/dnn_top2_tracker.sv - one combinational step of a running best/second-best tracker
//
// Purpose: given the current (best, second, best_idx) and a new candidate v at
// index idx, produce the updated triple. Strict comparisons, so the earliest
// index wins among equal maxima and a tied value lands in second.
//
// Ports:
//   first         in   restart tracking with v as the only element seen
//   idx           in   index of candidate v
//   v             in   signed candidate value
//   best          in   current best value
//   second        in   current runner-up value
//   best_idx      in   index of current best
//   best_nxt      out  updated best
//   second_nxt    out  updated runner-up
//   best_idx_nxt  out  updated best index
module dnn_top2_tracker
    import dnn_pkg::*;
#(
    parameter int DATA_WIDTH = DNN_DATA_WIDTH,
    parameter int IDX_WIDTH  = DNN_IDX_WIDTH
) (
    input  logic                         first,
    input  logic [IDX_WIDTH-1:0]         idx,
    input  logic signed [DATA_WIDTH-1:0] v,
    input  logic signed [DATA_WIDTH-1:0] best,
    input  logic signed [DATA_WIDTH-1:0] second,
    input  logic [IDX_WIDTH-1:0]         best_idx,
    output logic signed [DATA_WIDTH-1:0] best_nxt,
    output logic signed [DATA_WIDTH-1:0] second_nxt,
    output logic [IDX_WIDTH-1:0]         best_idx_nxt
);

    // Most negative representable value: seeds second so any real element beats it.
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        best_nxt     = best;
        second_nxt   = second;
        best_idx_nxt = best_idx;
        if (first) begin
            best_nxt     = v;
            second_nxt   = MOST_NEG;
            best_idx_nxt = '0;
        end else if (v > best) begin
            second_nxt   = best;
            best_nxt     = v;
            best_idx_nxt = idx;
        end else if (v > second) begin
            second_nxt   = v;
        end
    end

endmodule

// File: rtl/dnn_argmax_seq.sv
// rtl/dnn_argmax_seq.sv - sequential argmax over the inference engine's output activations
//
// Purpose: on an accepted start, snapshot all class activations, scan them one
// per cycle, then report the winning class, its activation and the margin to
// the runner-up. Results hold with done high until the next accepted start.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   start pulse, accepted only in IDLE or HOLD
//   scores     in   packed activations, neuron i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy       out  high during SCAN and FIN
//   done       out  high in HOLD
//   digit      out  index of the maximum activation
//   max_score  out  signed maximum activation
//   margin     out  unsigned best minus runner-up, DATA_WIDTH+1 bits
module dnn_argmax_seq
    import dnn_pkg::*;
#(
    parameter int DATA_WIDTH  = DNN_DATA_WIDTH,
    parameter int NUM_CLASSES = DNN_NUM_CLASSES,
    parameter int IDX_WIDTH   = DNN_IDX_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0]   scores,
    output logic                                busy,
    output logic                                done,
    output logic [IDX_WIDTH-1:0]                digit,
    output logic signed [DATA_WIDTH-1:0]        max_score,
    output logic [DATA_WIDTH:0]                 margin
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    argmax_state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] snap_q [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] snap_d [NUM_CLASSES];
    logic [IDX_WIDTH-1:0]         idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0] best_q, best_d;
    logic signed [DATA_WIDTH-1:0] second_q, second_d;
    logic [IDX_WIDTH-1:0]         best_idx_q, best_idx_d;
    logic [IDX_WIDTH-1:0]         digit_q, digit_d;
    logic signed [DATA_WIDTH-1:0] max_score_q, max_score_d;
    logic [DATA_WIDTH:0]          margin_q, margin_d;

    logic                         start_ok;
    logic signed [DATA_WIDTH-1:0] cur_v;
    logic signed [DATA_WIDTH-1:0] trk_best, trk_second;
    logic [IDX_WIDTH-1:0]         trk_best_idx;

    assign start_ok = start && (state_q == IDLE || state_q == HOLD);
    assign cur_v    = snap_q[idx_q];

    dnn_top2_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_tracker (
        .first        (idx_q == '0),
        .idx          (idx_q),
        .v            (cur_v),
        .best         (best_q),
        .second       (second_q),
        .best_idx     (best_idx_q),
        .best_nxt     (trk_best),
        .second_nxt   (trk_second),
        .best_idx_nxt (trk_best_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HOLD: if (start_ok) state_d = SCAN;
            SCAN:       if (idx_q == LAST_IDX) state_d = FIN;
            FIN:        state_d = HOLD;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; result fields come from their own registers
    always_comb begin
        busy      = (state_q == SCAN) || (state_q == FIN);
        done      = (state_q == HOLD);
        digit     = digit_q;
        max_score = max_score_q;
        margin    = margin_q;
    end

    // Datapath next-values
    always_comb begin
        snap_d      = snap_q;
        idx_d       = idx_q;
        best_d      = best_q;
        second_d    = second_q;
        best_idx_d  = best_idx_q;
        digit_d     = digit_q;
        max_score_d = max_score_q;
        margin_d    = margin_q;
        case (state_q)
            IDLE, HOLD: begin
                if (start_ok) begin
                    for (int i = 0; i < NUM_CLASSES; i++) begin
                        snap_d[i] = scores[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    idx_d = '0;
                end
            end
            SCAN: begin
                best_d     = trk_best;
                second_d   = trk_second;
                best_idx_d = trk_best_idx;
                if (idx_q != LAST_IDX) idx_d = idx_q + IDX_WIDTH'(1);
            end
            FIN: begin
                digit_d     = best_idx_q;
                max_score_d = best_q;
                // Sign-extend both operands one bit; best >= second so the
                // difference is non-negative and fits without saturation.
                margin_d    = {best_q[DATA_WIDTH-1], best_q} - {second_q[DATA_WIDTH-1], second_q};
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                snap_q[i] <= '0;
            end
            idx_q       <= '0;
            best_q      <= '0;
            second_q    <= '0;
            best_idx_q  <= '0;
            digit_q     <= '0;
            max_score_q <= '0;
            margin_q    <= '0;
        end else begin
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            second_q    <= second_d;
            best_idx_q  <= best_idx_d;
            digit_q     <= digit_d;
            max_score_q <= max_score_d;
            margin_q    <= margin_d;
        end
    end

endmodule

// File: tb/tb_dnn_argmax_seq.sv
// tb/tb_dnn_argmax_seq.sv - scoreboard bench for dnn_argmax_seq
module tb_dnn_argmax_seq;

    localparam int DW = 7;
    localparam int NC = 10;
    localparam int IW = 4;

    typedef struct {
        int digit;
        int maxv;
        int margin;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [NC*DW-1:0]     scores;
    logic                 busy;
    logic                 done;
    logic [IW-1:0]        digit;
    logic signed [DW-1:0] max_score;
    logic [DW:0]          margin;

    int   vectors = 0;
    int   miscompares = 0;
    int   sc [NC];
    exp_t sb [$];

    always #5 clk = ~clk;

    dnn_argmax_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .scores    (scores),
        .busy      (busy),
        .done      (done),
        .digit     (digit),
        .max_score (max_score),
        .margin    (margin)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic apply_scores();
        for (int i = 0; i < NC; i++) scores[i*DW +: DW] = DW'(sc[i]);
    endtask

    function automatic exp_t model();
        exp_t e;
        int bi = 0;
        int sec = -1000;
        for (int i = 1; i < NC; i++) if (sc[i] > sc[bi]) bi = i;
        for (int j = 0; j < NC; j++) if (j != bi && sc[j] > sec) sec = sc[j];
        e.digit  = bi;
        e.maxv   = sc[bi];
        e.margin = sc[bi] - sec;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a scan on the current sc[] and wait for done; optionally scramble
    // inputs and pulse start during the scan, or check the old digit holds.
    task automatic run_scan(input string tag, input bit disturb, input bit chk_hold, input int old_digit);
        exp_t e;
        int   cyc;
        apply_scores();
        start = 1'b1;
        sb.push_back(model());
        tick();
        start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy), 1);
        chk({tag, "_done_fall"}, 32'(done), 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (disturb) begin
                scores = 70'({$urandom(), $urandom(), $urandom()});
                start  = (cyc == 3);
            end
            tick();
            cyc++;
            if (chk_hold && cyc == 10) chk({tag, "_old_digit_held"}, 32'(digit), old_digit);
        end
        start = 1'b0;
        chk({tag, "_latency"}, cyc, 11);
        chk({tag, "_busy_fall"}, 32'(busy), 0);
        e = sb.pop_front();
        chk({tag, "_digit"}, 32'(digit), e.digit);
        chk({tag, "_max_score"}, 32'(max_score), e.maxv);
        chk({tag, "_margin"}, 32'(margin), e.margin);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        scores = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_digit", 32'(digit), 0);
        chk("rst_max_score", 32'(max_score), 0);
        chk("rst_margin", 32'(margin), 0);
        tick();

        sc = '{3, -10, 25, 7, -64, 0, 12, 24, -1, 5};
        run_scan("distinct", 1'b0, 1'b0, 0);
        chk("distinct_const_digit", 32'(digit), 2);
        chk("distinct_const_margin", 32'(margin), 1);

        sc = '{0, 0, 0, 0, 40, 0, 0, 40, 0, 0};
        run_scan("tie_40", 1'b0, 1'b0, 0);

        sc = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5};
        run_scan("all_equal", 1'b0, 1'b0, 0);

        sc = '{-64, -64, -64, -64, -64, -64, -64, -64, -64, 63};
        run_scan("extremes", 1'b0, 1'b0, 0);
        chk("extremes_const_margin", 32'(margin), 127);

        sc = '{1, 2, 3, -4, 20, 6, 7, 8, 9, 10};
        run_scan("snapshot", 1'b1, 1'b0, 0);
        tick();

        // Abort a scan with rst sampled at the fifth edge after acceptance.
        sc = '{11, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        apply_scores();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_digit", 32'(digit), 0);
        chk("abort_max_score", 32'(max_score), 0);
        chk("abort_margin", 32'(margin), 0);
        tick();

        sc = '{3, -10, 25, 7, -64, 0, 12, 24, -1, 5};
        run_scan("after_abort", 1'b0, 1'b0, 0);

        sc = '{0, 1, 2, 3, 4, 5, 33, 30, -7, 6};
        run_scan("back_to_back", 1'b0, 1'b1, 2);
        chk("back_to_back_const_digit", 32'(digit), 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dnn_argmax_seq.md
Name: dnn_argmax_seq

Overview:
- Classification stage directly downstream of the fixed-point sigmoid inference engine.
- When the engine signals done, this block snapshots its 10 signed output-neuron activations.
- It scans them sequentially, one per cycle, and reports the recognised digit (argmax), the winning activation, and the margin to the runner-up.
- Results feed the top-level result register / display logic.

Parameters:
- DATA_WIDTH, 7, width of each signed activation (Q-format as produced by the engine).
- NUM_CLASSES, 10, number of output neurons; must be >= 2.
- IDX_WIDTH, 4, width of the class index; must satisfy 2**IDX_WIDTH >= NUM_CLASSES.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; normally tied to the engine's done rising edge.
- scores  in  DATA_WIDTH x NUM_CLASSES  signed activations, scores[i] = neuron i; sampled only on an accepted start.
- busy  out  1  high while scanning.
- done  out  1  level; high from scan completion until the next accepted start or rst.
- digit  out  IDX_WIDTH  index of the maximum activation; valid while done.
- max_score  out  DATA_WIDTH  signed maximum activation; valid while done.
- margin  out  DATA_WIDTH+1  unsigned (max_score - second-highest activation); valid while done.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, digit=0, max_score=0, margin=0.
  - Index counter and snapshot registers cleared.
  - rst has priority over start in the same cycle.
- States:
  - IDLE: waits for start.
  - SCAN: processes one element per cycle.
  - FIN: computes margin and registers results.
  - HOLD: results valid, done high.
- Start acceptance:
  - start is accepted in IDLE or HOLD.
  - start is ignored in SCAN and FIN; no restart, no snapshot.
- Accepted start at edge T:
  - All scores copied into an internal snapshot array.
  - idx=0, busy rises at T+1, done falls at T+1.
  - state=SCAN.
  - Upstream may change scores after T without affecting the result.
- SCAN, per cycle, v = snapshot[idx]:
  - idx==0: best=v, best_idx=0, second=most-negative DATA_WIDTH value (-64 for 7 bits).
  - Else if v > best (strict, signed): second=best, best=v, best_idx=idx.
  - Else if v > second: second=v.
  - If idx==NUM_CLASSES-1, go to FIN; else idx++.
- Tie rule: strict comparison, so the lowest index wins among equal maxima. A tied value updates second, so margin = 0.
- FIN (one cycle):
  - digit=best_idx, max_score=best.
  - margin = best - second, computed in DATA_WIDTH+1 bits. The result is always >= 0 and needs no saturation (max 127 for 7 bits).
  - state=HOLD.
- HOLD: busy=0, done=1, outputs stable.
- Latency: start accepted at edge T → busy high on cycles T+1..T+NUM_CLASSES+1 → done high at T+NUM_CLASSES+2 (12 cycles for default). Fixed and data-independent.
- Back-to-back: start in HOLD drops done for exactly NUM_CLASSES+1 cycles, then re-asserts with new results. Outputs digit/max_score/margin retain old values until FIN overwrites them.
- rst mid-SCAN/FIN: abort immediately, all outputs to reset values, no done pulse.
- All arithmetic signed except margin; no X propagation from unused snapshot entries.

Decomposition:
- Shared package dnn_pkg holds:
  - DNN_DATA_WIDTH=7, DNN_NUM_CLASSES=10, DNN_IDX_WIDTH=4.
  - Typedef act_t (signed [6:0]) and cls_idx_t ([3:0]).
  - State enum argmax_state_t {IDLE, SCAN, FIN, HOLD}.
- One natural sub-module: dnn_top2_tracker, the combinational best/second/best_idx update step. It takes the current state and v, and returns the next state. It is reusable for a parallel argmax later.
- The FSM, snapshot and counter stay in dnn_argmax_seq.

Test Plan:
- Distinct values: scores = {3,-10,25,7,-64,0,12,24,-1,5} (index 0..9), start pulse → done exactly 12 cycles after start; digit=2, max_score=25, margin=1.
- Tie: scores[4]=scores[7]=40, others 0 → digit=4, max_score=40, margin=0. All ten equal to -5 → digit=0, margin=0.
- Extremes: scores[9]=63, others -64 → digit=9, max_score=63, margin=127 (8-bit, no wrap).
- Snapshot and ignored start:
  - Change scores on every cycle after start; result must match the values at the start edge.
  - Pulse start mid-SCAN: no restart, done still at T+12.
- rst at cycle T+5 of a scan: the next cycle shows busy=0, done=0, digit=0, margin=0; a subsequent start produces correct results.
- Back-to-back: start while done=1 with new scores (winner at index 6) → done low for 11 cycles, old digit held until FIN, then digit=6.
